// File: rtl/glyph_row_renderer_if.sv
// Bus between the glyph row renderer, the text buffer, the char ROM and video timing.
// The renderer connects through the slave modport.
interface glyph_row_renderer_if #(
  parameter int COL_W = 4
);
  logic             line_start;
  logic [2:0]       glyph_row;
  logic             pix_en;
  logic [COL_W-1:0] char_col;
  logic [6:0]       char_code;
  logic [6:0]       rom_addr;
  logic [34:0]      rom_data;
  logic             pixel;
  logic             busy;
  logic             underrun;

  modport master (
    output line_start, glyph_row, pix_en, char_code, rom_data,
    input  char_col, rom_addr, pixel, busy, underrun
  );

  modport slave (
    input  line_start, glyph_row, pix_en, char_code, rom_data,
    output char_col, rom_addr, pixel, busy, underrun
  );
endinterface

// File: rtl/glyph_row_renderer.sv
// Scanline renderer for the 5x7 character ROM: fetches each cell's code, slices the
// glyph row and serializes it as a scaled pixel stream while prefetching the next cell.
module glyph_row_renderer #(
  parameter int NUM_COLS = 10,
  parameter int CELL_W   = 6,
  parameter int SCALE    = 2,
  parameter int COL_W    = $clog2(NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  glyph_row_renderer_if.slave bus
);
  localparam int                 CELL_CW       = $clog2(CELL_W);
  localparam logic [COL_W-1:0]   LAST_COL      = COL_W'(NUM_COLS - 1);
  localparam logic [CELL_CW-1:0] LAST_CELL_CTR = CELL_CW'(CELL_W - 1);
  localparam logic [1:0]         LAST_SCALE    = 2'(SCALE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ADDR, S_LOAD, S_ACTIVE} state_t;
  typedef enum logic [1:0] {PF_NONE, PF_FETCH, PF_ADDR, PF_LOAD} pf_phase_t;

  state_t             state_q, state_d;
  pf_phase_t          pf_phase_q;
  logic [2:0]         row_q;
  logic [4:0]         shift_q, pf_q, slice, cur_slice;
  logic               pf_valid_q, last_cell_q;
  logic [CELL_CW-1:0] cell_ctr_q;
  logic [1:0]         scale_ctr_q;
  logic [COL_W-1:0]   char_col_q;
  logic [6:0]         rom_addr_q;
  logic               pixel_q, busy_q, underrun_q;
  logic               strobe, cell_enter, cell_wrap, line_end, pix_bit;

  assign bus.char_col = char_col_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.pixel    = pixel_q;
  assign bus.busy     = busy_q;
  assign bus.underrun = underrun_q;

  // Row 7 is the blank gap between text rows.
  assign slice = (row_q == 3'd7) ? 5'b00000 : 5'(bus.rom_data >> (int'(row_q) * 5));

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    state_d    = state_q;
    strobe     = bus.pix_en && (state_q == S_ACTIVE);
    cell_enter = (cell_ctr_q == '0) && (scale_ctr_q == '0);
    cell_wrap  = (cell_ctr_q == LAST_CELL_CTR) && (scale_ctr_q == LAST_SCALE);
    line_end   = strobe && cell_wrap && last_cell_q;
    // On the first strobe of a cell the prefetched slice is used directly.
    cur_slice  = cell_enter ? (pf_valid_q ? pf_q : 5'b00000) : shift_q;
    pix_bit    = (cell_ctr_q < CELL_CW'(5)) ? cur_slice[cell_ctr_q[2:0]] : 1'b0;
    if (bus.line_start) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_ADDR;
        S_ADDR:   state_d = S_LOAD;
        S_LOAD:   state_d = S_ACTIVE;
        S_ACTIVE: if (line_end) state_d = S_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pf_phase_q  <= PF_NONE;
      row_q       <= '0;
      shift_q     <= '0;
      pf_q        <= '0;
      pf_valid_q  <= 1'b0;
      last_cell_q <= 1'b0;
      cell_ctr_q  <= '0;
      scale_ctr_q <= '0;
      char_col_q  <= '0;
      rom_addr_q  <= '0;
      pixel_q     <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else if (bus.line_start) begin
      row_q       <= bus.glyph_row;
      char_col_q  <= '0;
      busy_q      <= 1'b1;
      underrun_q  <= 1'b0;
      shift_q     <= '0;
      pf_q        <= '0;
      pf_valid_q  <= 1'b0;
      pf_phase_q  <= PF_NONE;
      cell_ctr_q  <= '0;
      scale_ctr_q <= '0;
      last_cell_q <= 1'b0;
      if (bus.pix_en) pixel_q <= 1'b0;
    end else begin
      case (state_q)
        S_ADDR: rom_addr_q <= bus.char_code;
        S_LOAD: begin
          pf_q       <= slice;
          pf_valid_q <= 1'b1;
        end
        default: ;
      endcase
      // Background fetch of the next cell runs on clock cycles, not strobes.
      if (state_q == S_ACTIVE) begin
        case (pf_phase_q)
          PF_FETCH: pf_phase_q <= PF_ADDR;
          PF_ADDR: begin
            rom_addr_q <= bus.char_code;
            pf_phase_q <= PF_LOAD;
          end
          PF_LOAD: begin
            pf_q       <= slice;
            pf_valid_q <= 1'b1;
            pf_phase_q <= PF_NONE;
          end
          default: ;
        endcase
      end
      if (bus.pix_en) begin
        pixel_q <= strobe ? pix_bit : 1'b0;
        if (busy_q && (state_q != S_ACTIVE)) underrun_q <= 1'b1;
      end
      if (strobe) begin
        if (cell_enter) begin
          shift_q     <= cur_slice;
          pf_valid_q  <= 1'b0;
          last_cell_q <= (char_col_q == LAST_COL);
          if (!pf_valid_q) underrun_q <= 1'b1;
          if (char_col_q != LAST_COL) begin
            char_col_q <= char_col_q + COL_W'(1);
            pf_phase_q <= PF_FETCH;
          end
        end
        if (scale_ctr_q == LAST_SCALE) begin
          scale_ctr_q <= '0;
          cell_ctr_q  <= cell_wrap ? '0 : cell_ctr_q + CELL_CW'(1);
        end else begin
          scale_ctr_q <= scale_ctr_q + 2'd1;
        end
        if (line_end) busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_glyph_row_renderer.sv
// Self-checking bench for glyph_row_renderer: table-driven glyph vectors, randomized
// lines against a strobe-indexed pixel model, and hand-written restart/reset sequences.
module tb_glyph_row_renderer;
  localparam int NUM_COLS     = 4;
  localparam int CELL_W       = 6;
  localparam int SCALE        = 2;
  localparam int COL_W        = $clog2(NUM_COLS);
  localparam int CELL_STROBES = CELL_W * SCALE;
  localparam int LINE_STROBES = NUM_COLS * CELL_STROBES;
  localparam logic [34:0] GLYPH_A = {5'b10001, 5'b10001, 5'b10001, 5'b11111,
                                     5'b10001, 5'b10001, 5'b01110};

  typedef struct {
    logic [2:0] row;
    logic [6:0] code;
    logic [4:0] slice;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic exp_pix = 1'b0;
  bit   exp_known = 1'b0;
  logic [63:0] rnd;
  logic [34:0] rom [128];
  logic [6:0]  text [NUM_COLS];
  vec_t tab [6];

  glyph_row_renderer_if #(.COL_W(COL_W)) bus();

  glyph_row_renderer #(
    .NUM_COLS(NUM_COLS), .CELL_W(CELL_W), .SCALE(SCALE), .COL_W(COL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Char ROM is combinational; the text buffer answers one cycle after char_col changes.
  assign bus.rom_data = rom[bus.rom_addr];
  always @(posedge clk) bus.char_code <= text[bus.char_col];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pixel after strobe n of a line: cell = n / (CELL_W*SCALE), glyph column = (n/SCALE) % CELL_W.
  function automatic logic model_pixel(input logic [2:0] row, input int n);
    int col;
    int c;
    logic [34:0] w;
    col = n / CELL_STROBES;
    c   = (n / SCALE) % CELL_W;
    if (row == 3'd7 || c >= 5) return 1'b0;
    w = rom[text[col]];
    return w[int'(row) * 5 + c];
  endfunction

  task automatic randomize_text();
    for (int i = 0; i < NUM_COLS; i++) text[i] = 7'($urandom_range(0, 127));
  endtask

  task automatic start_line(input logic [2:0] row, input logic pe);
    bus.glyph_row  = row;
    bus.line_start = 1'b1;
    bus.pix_en     = pe;
    step();
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
    if (pe) exp_known = 1'b0;
    check("start_char_col", bus.char_col, 0);
    check("start_busy", bus.busy, 1);
    step();
    step();
    step();
  endtask

  task automatic render(input logic [2:0] row, input int density, input int stop_at,
                        input bit use_tab, input logic [4:0] tab_slice);
    int n;
    int budget;
    int c;
    logic pe;
    logic exp;
    n = 0;
    budget = 4000;
    while (n < stop_at && budget > 0) begin
      pe = ($urandom_range(0, 99) < density);
      bus.pix_en = pe;
      step();
      budget--;
      if (pe) begin
        c = (n / SCALE) % CELL_W;
        if (use_tab) exp = (c < 5) ? tab_slice[c] : 1'b0;
        else         exp = model_pixel(row, n);
        exp_pix   = exp;
        exp_known = 1'b1;
        check($sformatf("pixel row%0d strobe%0d", row, n), bus.pixel, exp);
        n++;
      end else if (exp_known) begin
        check("pixel_hold", bus.pixel, exp_pix);
      end
      check($sformatf("busy strobe%0d", n), bus.busy, n < LINE_STROBES);
    end
    bus.pix_en = 1'b0;
    if (n < stop_at) check("render_budget", n, stop_at);
  endtask

  task automatic run_line(input logic [2:0] row, input int density, input bit use_tab,
                          input logic [4:0] tab_slice);
    start_line(row, 1'b0);
    render(row, density, LINE_STROBES, use_tab, tab_slice);
    check("line_underrun", bus.underrun, 0);
    for (int i = 0; i < 2; i++) begin
      bus.pix_en = 1'b1;
      step();
      check("idle_pixel", bus.pixel, 0);
      check("idle_busy", bus.busy, 0);
    end
    bus.pix_en = 1'b0;
    exp_pix = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      rnd = {$urandom, $urandom};
      rom[i] = rnd[34:0];
    end
    rom[65]  = GLYPH_A;
    rom[127] = '1;
    rom[32]  = '0;
    for (int i = 0; i < NUM_COLS; i++) text[i] = 7'd0;
    tab[0] = '{3'd0, 7'd65,  5'b01110};
    tab[1] = '{3'd3, 7'd65,  5'b11111};
    tab[2] = '{3'd6, 7'd65,  5'b10001};
    tab[3] = '{3'd3, 7'd127, 5'b11111};
    tab[4] = '{3'd7, 7'd127, 5'b00000};
    tab[5] = '{3'd2, 7'd32,  5'b00000};
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
    bus.glyph_row  = 3'd0;

    step();
    step();
    check("reset_pixel", bus.pixel, 0);
    check("reset_char_col", bus.char_col, 0);
    check("reset_rom_addr", bus.rom_addr, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_underrun", bus.underrun, 0);
    rst_n = 1'b1;
    step();
    exp_known = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NUM_COLS; k++) text[k] = tab[i].code;
      run_line(tab[i].row, 100, 1'b1, tab[i].slice);
    end

    // Strobe while the first glyph is still being fetched.
    randomize_text();
    bus.glyph_row  = 3'd1;
    bus.line_start = 1'b1;
    step();
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b1;
    step();
    bus.pix_en = 1'b0;
    check("underrun_set", bus.underrun, 1);
    check("underrun_pixel", bus.pixel, 0);
    exp_pix = 1'b0;
    step();
    check("underrun_sticky", bus.underrun, 1);
    start_line(3'd1, 1'b0);
    check("underrun_cleared", bus.underrun, 0);
    render(3'd1, 100, LINE_STROBES, 1'b0, 5'b0);
    check("underrun_line_clean", bus.underrun, 0);

    for (int k = 0; k < 6; k++) begin
      randomize_text();
      run_line(3'($urandom_range(0, 7)), int'($urandom_range(40, 100)), 1'b0, 5'b0);
    end

    // Restart part-way through the third cell.
    randomize_text();
    start_line(3'd2, 1'b0);
    render(3'd2, 100, 2 * CELL_STROBES + 3, 1'b0, 5'b0);
    start_line(3'd4, 1'b0);
    render(3'd4, 70, LINE_STROBES, 1'b0, 5'b0);
    check("restart_underrun", bus.underrun, 0);

    // Restart coinciding with the final strobe of a line.
    randomize_text();
    start_line(3'd3, 1'b0);
    render(3'd3, 100, LINE_STROBES - 1, 1'b0, 5'b0);
    start_line(3'd5, 1'b1);
    render(3'd5, 100, LINE_STROBES, 1'b0, 5'b0);
    check("final_restart_underrun", bus.underrun, 0);

    // Reset in the middle of an active line.
    randomize_text();
    start_line(3'd5, 1'b0);
    render(3'd5, 100, 15, 1'b0, 5'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset_pixel", bus.pixel, 0);
    check("midreset_busy", bus.busy, 0);
    check("midreset_char_col", bus.char_col, 0);
    check("midreset_rom_addr", bus.rom_addr, 0);
    check("midreset_underrun", bus.underrun, 0);
    for (int i = 0; i < 8; i++) begin
      bus.pix_en = 1'b1;
      step();
      check("post_reset_pixel", bus.pixel, 0);
      check("post_reset_busy", bus.busy, 0);
    end
    bus.pix_en = 1'b0;
    exp_pix = 1'b0;
    randomize_text();
    run_line(3'd0, 80, 1'b0, 5'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
